butterfly_r2_pipe: RTL and testbench
====================================

// Module: butterfly_r2_pipe
// PURPOSE
//  Parametrised radix-2 DIT butterfly: yp = xp + xq*W, yq = xp - xq*W (complex, fixed point).
//  Successor to the fixed 24/16-bit butterfly inside the FFT datapath.
//  Adds: generic widths, per-sample inverse mode (conjugate W), per-sample right-shift scaling,
//  round-half-up, saturation with sticky overflow flag, and valid/ready backpressure.
// PARAMETERS
//  DW  24  data width, signed two's complement, all x/y ports
//  TW  16  twiddle width, signed Q1.(TW-1); -2^(TW-1) = -1.0 exactly
//  SW  2   width of scale input; max shift 2^SW-1
// PORTS
//  clk         in   1   single clock, all logic rising-edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   input beat present
//  in_ready    out  1   block accepts beat this cycle (in_valid & in_ready = accept)
//  inverse     in   1   1: use conj(W) (IFFT); sampled with beat
//  scale       in   SW  extra arithmetic right shift of results; sampled with beat
//  xp_real/xp_imag  in  DW  upper butterfly input
//  xq_real/xq_imag  in  DW  lower butterfly input
//  w_real/w_imag    in  TW  twiddle factor
//  out_valid   out  1   result beat present
//  out_ready   in   1   downstream accepts (out_valid & out_ready = transfer)
//  yp_real/yp_imag  out DW  xp + xq*W, scaled, rounded, saturated
//  yq_real/yq_imag  out DW  xp - xq*W, scaled, rounded, saturated
//  ovf_sticky  out  1   set when any output component saturated; held until cleared
//  ovf_clr     in   1   clears ovf_sticky (set wins if same cycle)
// BEHAVIOUR
//  - 3-stage pipeline: S1 conj+4 products, xp aligned <<(TW-1); S2 cross sums; S3 add/sub, round, saturate.
//  - Latency: accepted beat appears on out_valid exactly 3 cycles later when never stalled.
//  - Stall: advance = ~out_valid | out_ready; all stages (data+valid) hold when advance=0.
//    in_ready = advance (combinational from out_ready). Throughput 1 beat/cycle, no bubbles inserted.
//  - Bubbles (valid=0) in pipeline collapse: a stage with valid=0 is overwritten even when S3 stalled.
//  - Output regs hold value while out_valid & ~out_ready; no data change under stall.
//  - inverse=1: w_imag negated; -2^(TW-1) negates to +2^(TW-1)-1 (saturate), w_real unchanged.
//  - Products DW+TW bits; sums kept in DW+TW+1 bits, no intermediate truncation.
//  - Shift sh = TW-1+scale. Result = (sum + 2^(sh-1)) >>> sh, then saturate to [-2^(DW-1), 2^(DW-1)-1].
//  - ovf_sticky sets the cycle after a saturating S3 result is registered; counts only valid beats.
//  - Reset (rst=1, any cycle incl. mid-stream): all valid bits 0, all data regs 0, ovf_sticky 0,
//    out_valid=0, y*=0; in-flight beats discarded; in_ready=1 the cycle after rst deasserts.
//  - inverse/scale are per-beat: changing them between consecutive beats affects only later beats.
// TESTING (DW=24, TW=16, SW=2)
//  1 xp=(1000,0) xq=(500,0) W=(-32768,0) scale=0 -> yp=(500,0) yq=(1500,0), out_valid 3 cycles after accept.
//  2 same, scale=1 -> yp=(250,0) yq=(750,0); scale=3 -> yp=(63,0) yq=(188,0) (round half up).
//  3 xp=xq=(8388607,0) W=(-32768,0) -> yp=(0,0) yq=(8388607,0) saturated, ovf_sticky=1 until ovf_clr.
//  4 xp=0 xq=(0,1000) W=(0,-32768): inverse=0 -> yp=(1000,0) yq=(-1000,0);
//    inverse=1 -> yp=(-1000,0) yq=(1000,0).
//  5 stream 8 beats back-to-back, out_ready low cycles 4-6 -> in_ready low same cycles,
//    all 8 results in order, none lost/duplicated, outputs stable while stalled.
//  6 rst pulsed with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted afterwards.

Source files
------------

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, 3-stage valid/ready pipeline:
// yp = xp + xq*W, yq = xp - xq*W, with optional conj(W), scaling, rounding and saturation.
module butterfly_r2_pipe #(
    parameter int DW = 24,
    parameter int TW = 16,
    parameter int SW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inverse,
    input  logic [SW-1:0]        scale,
    input  logic signed [DW-1:0] xp_real,
    input  logic signed [DW-1:0] xp_imag,
    input  logic signed [DW-1:0] xq_real,
    input  logic signed [DW-1:0] xq_imag,
    input  logic signed [TW-1:0] w_real,
    input  logic signed [TW-1:0] w_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] yp_real,
    output logic signed [DW-1:0] yp_imag,
    output logic signed [DW-1:0] yq_real,
    output logic signed [DW-1:0] yq_imag,
    output logic                 ovf_sticky,
    input  logic                 ovf_clr
);

    localparam int PW   = DW + TW;
    localparam int SUMW = DW + TW + 1;
    localparam int AW   = DW + TW + 2;

    localparam logic signed [TW-1:0] WMIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] WMAX = ~WMIN;
    localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = ~YMAX;

    // Stage enables: an empty stage may always refill, even while S3 is stalled.
    logic advance, en2, en1;
    logic v1_q, v2_q, out_valid_q;

    assign advance   = ~out_valid_q | out_ready;
    assign en2       = advance | ~v2_q;
    assign en1       = en2 | ~v1_q;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;

    // ---------------- S1: conjugate, four products, xp alignment ----------------
    logic signed [TW-1:0]   wi_eff;
    logic signed [PW-1:0]   p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0]   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [SUMW-1:0] xpr1_d, xpi1_d, xpr1_q, xpi1_q;
    logic [SW-1:0]          sc1_q;

    always_comb begin
        wi_eff = w_imag;
        if (inverse) begin
            wi_eff = (w_imag == WMIN) ? WMAX : -w_imag;
        end
        p_rr_d = PW'(xq_real) * PW'(w_real);
        p_ii_d = PW'(xq_imag) * PW'(wi_eff);
        p_ri_d = PW'(xq_real) * PW'(wi_eff);
        p_ir_d = PW'(xq_imag) * PW'(w_real);
        xpr1_d = SUMW'(xp_real) <<< (TW - 1);
        xpi1_d = SUMW'(xp_imag) <<< (TW - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            xpr1_q <= '0;
            xpi1_q <= '0;
            sc1_q  <= '0;
        end else if (en1) begin
            v1_q   <= in_valid & advance;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            xpr1_q <= xpr1_d;
            xpi1_q <= xpi1_d;
            sc1_q  <= scale;
        end
    end

    // ---------------- S2: complex cross sums ----------------
    logic signed [SUMW-1:0] tr_d, ti_d, tr_q, ti_q, xpr2_q, xpi2_q;
    logic [SW-1:0]          sc2_q;

    always_comb begin
        tr_d = SUMW'(p_rr_q) - SUMW'(p_ii_q);
        ti_d = SUMW'(p_ri_q) + SUMW'(p_ir_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            tr_q   <= '0;
            ti_q   <= '0;
            xpr2_q <= '0;
            xpi2_q <= '0;
            sc2_q  <= '0;
        end else if (en2) begin
            v2_q   <= v1_q;
            tr_q   <= tr_d;
            ti_q   <= ti_d;
            xpr2_q <= xpr1_q;
            xpi2_q <= xpi1_q;
            sc2_q  <= sc1_q;
        end
    end

    // ---------------- S3: add/sub, round half up, saturate ----------------
    // Returns {saturated, value}.
    function automatic logic [DW:0] rnd_sat(input logic signed [AW-1:0] s,
                                            input logic [SW-1:0] sc);
        int sh;
        logic signed [AW-1:0] r;
        sh = TW - 1 + int'(sc);
        r  = (s + (AW'(1) <<< (sh - 1))) >>> sh;
        if (r > YMAX) begin
            return {1'b1, YMAX[DW-1:0]};
        end else if (r < YMIN) begin
            return {1'b1, YMIN[DW-1:0]};
        end
        return {1'b0, r[DW-1:0]};
    endfunction

    logic [DW:0] ypr_d, ypi_d, yqr_d, yqi_d;
    logic        sat_d;

    always_comb begin
        ypr_d = rnd_sat(AW'(xpr2_q) + AW'(tr_q), sc2_q);
        ypi_d = rnd_sat(AW'(xpi2_q) + AW'(ti_q), sc2_q);
        yqr_d = rnd_sat(AW'(xpr2_q) - AW'(tr_q), sc2_q);
        yqi_d = rnd_sat(AW'(xpi2_q) - AW'(ti_q), sc2_q);
        sat_d = ypr_d[DW] | ypi_d[DW] | yqr_d[DW] | yqi_d[DW];
    end

    logic sat_pulse_q, ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            yp_real     <= '0;
            yp_imag     <= '0;
            yq_real     <= '0;
            yq_imag     <= '0;
            sat_pulse_q <= 1'b0;
        end else begin
            sat_pulse_q <= 1'b0;
            if (advance) begin
                out_valid_q <= v2_q;
                yp_real     <= ypr_d[DW-1:0];
                yp_imag     <= ypi_d[DW-1:0];
                yq_real     <= yqr_d[DW-1:0];
                yq_imag     <= yqi_d[DW-1:0];
                sat_pulse_q <= v2_q & sat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (sat_pulse_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Directed-vector bench for butterfly_r2_pipe (DW=24, TW=16, SW=2).
module tb_butterfly_r2_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, inverse, out_valid, out_ready;
    logic               ovf_sticky, ovf_clr;
    logic [1:0]         scale;
    logic signed [23:0] xp_real, xp_imag, xq_real, xq_imag;
    logic signed [15:0] w_real, w_imag;
    logic signed [23:0] yp_real, yp_imag, yq_real, yq_imag;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    butterfly_r2_pipe #(.DW(24), .TW(16), .SW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inverse(inverse), .scale(scale),
        .xp_real(xp_real), .xp_imag(xp_imag),
        .xq_real(xq_real), .xq_imag(xq_imag),
        .w_real(w_real), .w_imag(w_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .yp_real(yp_real), .yp_imag(yp_imag),
        .yq_real(yq_real), .yq_imag(yq_imag),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int xpr, input int xpi, input int xqr, input int xqi,
                         input int wr, input int wi, input logic inv, input int sc);
        xp_real = 24'(xpr);
        xp_imag = 24'(xpi);
        xq_real = 24'(xqr);
        xq_imag = 24'(xqi);
        w_real  = 16'(wr);
        w_imag  = 16'(wi);
        inverse = inv;
        scale   = 2'(sc);
    endtask

    // One isolated beat: check latency and all four outputs.
    task automatic run_vec(input string tag,
                           input int xpr, input int xpi, input int xqr, input int xqi,
                           input int wr, input int wi, input logic inv, input int sc,
                           input int epr, input int epi, input int eqr, input int eqi);
        int lat;
        @(negedge clk);
        drive(xpr, xpi, xqr, xqi, wr, wi, inv, sc);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check_eq({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 3);
        check_eq({tag, ".yp_re"}, yp_real, epr);
        check_eq({tag, ".yp_im"}, yp_imag, epi);
        check_eq({tag, ".yq_re"}, yq_real, eqr);
        check_eq({tag, ".yq_im"}, yq_imag, eqi);
    endtask

    // 8 back-to-back beats: xp=(10k,-k), xq=(k,0), W=-1 -> yp=(9k,-k), yq=(11k,-k).
    task automatic stream_test;
        int sent, rcv, k;
        logic iv_s, ir_s;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 8);
            drive(10 * (sent + 1), -(sent + 1), sent + 1, 0, -32768, 0, 1'b0, 0);
            #1;
            check_eq("strm.in_ready", in_ready, (cyc >= 4 && cyc <= 6) ? 0 : 1);
            if (out_valid) begin
                k = rcv + 1;
                check_eq("strm.yp_re", yp_real, 9 * k);
                check_eq("strm.yp_im", yp_imag, -k);
                check_eq("strm.yq_re", yq_real, 11 * k);
                check_eq("strm.yq_im", yq_imag, -k);
                if (out_ready) rcv++;
            end
            iv_s = in_valid;
            ir_s = in_ready;
            @(posedge clk);
            if (iv_s && ir_s) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("strm.sent", sent, 8);
        check_eq("strm.received", rcv, 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("strm.no_dup", out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.yp_re", yp_real, 0);
        check_eq("rst.yq_im", yq_imag, 0);
        check_eq("rst.ovf", ovf_sticky, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst.in_ready", in_ready, 1);

        run_vec("t1",    1000, 0, 500, 0, -32768, 0, 1'b0, 0, 500, 0, 1500, 0);
        check_eq("t1.ovf", ovf_sticky, 0);
        run_vec("t2s1",  1000, 0, 500, 0, -32768, 0, 1'b0, 1, 250, 0, 750, 0);
        run_vec("t2s3",  1000, 0, 500, 0, -32768, 0, 1'b0, 3, 63, 0, 188, 0);
        run_vec("t4fwd", 0, 0, 0, 1000, 0, -32768, 1'b0, 0, 1000, 0, -1000, 0);
        run_vec("t4inv", 0, 0, 0, 1000, 0, -32768, 1'b1, 0, -1000, 0, 1000, 0);
        @(negedge clk);
        check_eq("t4.ovf", ovf_sticky, 0);

        run_vec("t3", 8388607, 0, 8388607, 0, -32768, 0, 1'b0, 0, 0, 0, 8388607, 0);
        check_eq("t3.ovf_pre", ovf_sticky, 0);
        @(negedge clk);
        check_eq("t3.ovf_set", ovf_sticky, 1);
        repeat (2) @(negedge clk);
        check_eq("t3.ovf_hold", ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_eq("t3.ovf_clr", ovf_sticky, 0);

        stream_test();

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(100 + i, 0, 1, 0, -32768, 0, 1'b0, 0);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_eq("t6.out_valid", out_valid, 0);
        check_eq("t6.yp_re", yp_real, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6.in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t6.no_stale", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
